// File: rtl/div8_seq.sv
// div8_seq: sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV8_SIGNED_EN to add the signed_op port and truncating two's-complement division.
module div8_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV8_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [WIDTH:0]   p_sh, trial;
    logic [WIDTH-1:0] p_next, d_next;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;
    logic             accept;

`ifdef DIV8_SIGNED_EN
    logic a_neg, b_neg;
    logic q_neg_q, q_neg_d, r_neg_q, r_neg_d;
`endif

    // Remainder stays below the divisor, so WIDTH bits of P suffice between iterations;
    // only the shifted value needs the extra bit.
    always_comb begin
        p_sh   = {p_q, d_q[WIDTH-1]};
        trial  = p_sh - {1'b0, dvs_q};
        p_next = trial[WIDTH] ? p_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        d_next = {d_q[WIDTH-2:0], ~trial[WIDTH]};
`ifdef DIV8_SIGNED_EN
        a_neg   = signed_op & dividend[WIDTH-1];
        b_neg   = signed_op & divisor[WIDTH-1];
        dvd_mag = a_neg ? '0 - dividend : dividend;
        dvs_mag = b_neg ? '0 - divisor : divisor;
        quo_fix = q_neg_q ? '0 - d_next : d_next;
        rem_fix = r_neg_q ? '0 - p_next : p_next;
`else
        dvd_mag = dividend;
        dvs_mag = divisor;
        quo_fix = d_next;
        rem_fix = p_next;
`endif
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        d_d     = d_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
`ifdef DIV8_SIGNED_EN
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
`endif
        accept  = start && (state_q != StRun);

        unique case (state_q)
            StRun: begin
                p_d   = p_next;
                d_d   = d_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    quo_d   = quo_fix;
                    rem_d   = rem_fix;
                    dbz_d   = 1'b0;
                end
            end
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    cnt_d = '0;
                    p_d   = '0;
                    d_d   = dvd_mag;
                    dvs_d = dvs_mag;
`ifdef DIV8_SIGNED_EN
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
`endif
                    if (divisor == '0) begin
                        state_d = StDone;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            d_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef DIV8_SIGNED_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
`ifdef DIV8_SIGNED_EN
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
`endif
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Self-checking bench for div8_seq: directed cases plus randomized traffic against
// an arithmetic reference model that predicts every output on every cycle.
module tb_div8_seq;

    localparam int unsigned W  = 8;
    localparam int          WI = W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, dbz;
    logic [W-1:0] quotient, remainder;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    div8_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef DIV8_SIGNED_EN
        .signed_op  (sgn),
`endif
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(dbz)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain integer division; SV int division truncates toward zero.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic s, output logic [W-1:0] q,
                                    output logic [W-1:0] r);
        int sa, sb;
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        q  = W'(sa / sb);
        r  = W'(sa % sb);
    endfunction

    // Model state, indexed by rising-edge count.
    int           edge_n = 0;
    bit           model_valid = 0;
    logic [W-1:0] m_q, m_r, pend_q, pend_r;
    logic         m_z;
    int           busy_from = -10, busy_to = -10, done_edge = -10, pend_edge = -10;

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (rst) begin
            model_valid = 1;
            m_q = '0; m_r = '0; m_z = 1'b0;
            busy_from = -10; busy_to = -10; done_edge = -10; pend_edge = -10;
        end else begin
            if (edge_n == pend_edge) begin
                m_q = pend_q; m_r = pend_r; m_z = 1'b0; done_edge = edge_n;
            end
            if (start && !((edge_n - 1) >= busy_from && (edge_n - 1) <= busy_to)) begin
                if (divisor == '0) begin
                    m_q = '1; m_r = dividend; m_z = 1'b1; done_edge = edge_n;
                end else begin
                    ref_div(dividend, divisor, sgn, pend_q, pend_r);
                    pend_edge = edge_n + WI;
                    busy_from = edge_n;
                    busy_to   = edge_n + WI - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic e_busy, e_done;
        if (model_valid) begin
            e_busy = (edge_n >= busy_from) && (edge_n <= busy_to);
            e_done = (edge_n == done_edge);
            check("cycle {busy,done,dbz,q,r}", {busy, done, dbz, quotient, remainder},
                  {e_busy, e_done, m_z, m_q, m_r});
        end
    end

    // Called at a negedge; returns at the negedge right after the sampling edge.
    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        dividend = a; divisor = b; sgn = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat = 0; nbusy = 0;
        while (!done && lat < 40) begin
            nbusy += int'(busy);
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            n_total++;
            $display("FAIL done_timeout: done still %0b after %0d cycles, required 1", done, lat);
        end
    endtask

    task automatic op_chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez);
        int lat, nb;
        go(a, b, s);
        wait_done(lat, nb);
        check({nm, " latency"}, lat, (b == '0) ? 0 : W);
        check({nm, " busy cycles"}, nb, (b == '0) ? 0 : W);
        check({nm, " quotient"}, quotient, eq);
        check({nm, " remainder"}, remainder, er);
        check({nm, " div_by_zero"}, dbz, ez);
    endtask

    initial begin
        int lat, nb, ndone;
        repeat (2) @(negedge clk);
        check("reset outputs", {busy, done, dbz, quotient, remainder}, '0);
        rst = 1'b0;
        @(negedge clk);

        op_chk("200/7", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0);
        op_chk("5/0", 8'd5, 8'd0, 1'b0, 8'hFF, 8'h05, 1'b1);
        op_chk("255/1", 8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0);
        op_chk("3/10", 8'd3, 8'd10, 1'b0, 8'd0, 8'd3, 1'b0);
        op_chk("0/9", 8'd0, 8'd9, 1'b0, 8'd0, 8'd0, 1'b0);

        // Start during busy is ignored; start in the done cycle is accepted.
        go(8'd100, 8'd3, 1'b0);
        repeat (3) @(negedge clk);
        go(8'd50, 8'd5, 1'b0);
        wait_done(lat, nb);
        check("100/3 ignored-start latency", lat, W - 4);
        check("100/3 quotient", quotient, 8'd33);
        check("100/3 remainder", remainder, 8'd1);
        op_chk("50/5 back-to-back", 8'd50, 8'd5, 1'b0, 8'd10, 8'd0, 1'b0);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        go(8'd200, 8'd7, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort outputs", {busy, done, dbz, quotient, remainder}, '0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            ndone += int'(done);
        end
        check("abort done pulses", ndone, 0);
        op_chk("200/7 after abort", 8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0);

`ifdef DIV8_SIGNED_EN
        op_chk("-7/2", 8'hF9, 8'd2, 1'b1, 8'hFD, 8'hFF, 1'b0);
        op_chk("7/-2", 8'd7, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0);
        op_chk("-128/-1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
        op_chk("-5/0 signed", 8'hFB, 8'd0, 1'b1, 8'hFF, 8'hFB, 1'b1);
`endif

        // Random traffic: starts at any time, zero divisors, occasional resets.
        repeat (3000) begin
            rst      = ($urandom_range(0, 499) == 0);
            start    = ($urandom_range(0, 2) == 0);
            dividend = W'($urandom);
            divisor  = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
`ifdef DIV8_SIGNED_EN
            sgn      = 1'($urandom);
`endif
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

endmodule
